// File: rtl/cayde_ctrl_fsm_if.sv
// Instruction/data memory req/ack handshake between the cayde sequencer and its memories.
// The sequencer is the master: it raises requests and waits for the memory acknowledges.
interface cayde_ctrl_fsm_if;
   logic imem_req;
   logic imem_ack;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;

   modport master (
      output imem_req,
      output dmem_req,
      output dmem_we,
      input  imem_ack,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      input  dmem_we,
      output imem_ack,
      output dmem_ack
   );
endinterface

// File: rtl/cayde_ctrl_fsm.sv
// Multi-cycle control sequencer for the cayde core: fetch, decode, execute, memory, writeback,
// with variable-latency memory handshakes and a sticky trap on illegal opcodes or timeouts.
module cayde_ctrl_fsm #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   cayde_ctrl_fsm_if.master   mem,
   input  logic               run,
   input  logic [6:0]         opcode,
   input  logic               branch_taken,
   output logic               ir_we,
   output logic               alu_src_imm,
   output logic [1:0]         wb_sel,
   output logic [1:0]         pc_sel,
   output logic               pc_we,
   output logic               reg_write,
   output logic               trap,
   output logic [1:0]         trap_cause,
   output logic [2:0]         state_o,
   output logic [CNT_W-1:0]   instret
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StTrap   = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      ClsR, ClsIalu, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsLui
   } cls_e;

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpIalu   = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpLui    = 7'b0110111;

   localparam logic [1:0] CauseIllegal = 2'd1;
   localparam logic [1:0] CauseImem    = 2'd2;
   localparam logic [1:0] CauseDmem    = 2'd3;

   // Last wait-count value before a pending request times out.
   localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

   state_e           state_q, state_d;
   cls_e             cls_q, cls_d;
   logic             taken_q, taken_d;
   logic [1:0]       cause_q, cause_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cls_q     <= ClsR;
         taken_q   <= 1'b0;
         cause_q   <= 2'd0;
         wait_q    <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         taken_q   <= taken_d;
         cause_q   <= cause_d;
         wait_q    <= wait_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cls_d        = cls_q;
      taken_d      = taken_q;
      cause_d      = cause_q;
      wait_d       = wait_q;
      instret_d    = instret_q;
      mem.imem_req = 1'b0;
      mem.dmem_req = 1'b0;
      mem.dmem_we  = 1'b0;
      ir_we        = 1'b0;
      alu_src_imm  = 1'b0;
      wb_sel       = 2'd0;
      pc_sel       = 2'd0;
      pc_we        = 1'b0;
      reg_write    = 1'b0;
      trap         = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (run) state_d = StFetch;
         end
         StFetch: begin
            mem.imem_req = 1'b1;
            if (mem.imem_ack) begin
               ir_we   = 1'b1;
               state_d = StDecode;
            end else if (wait_q == LastWait) begin
               state_d = StTrap;
               cause_d = CauseImem;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         StDecode: begin
            state_d = StExec;
            case (opcode)
               OpR:      cls_d = ClsR;
               OpIalu:   cls_d = ClsIalu;
               OpLoad:   cls_d = ClsLoad;
               OpStore:  cls_d = ClsStore;
               OpBranch: cls_d = ClsBranch;
               OpJal:    cls_d = ClsJal;
               OpLui:    cls_d = ClsLui;
               default: begin
                  state_d = StTrap;
                  cause_d = CauseIllegal;
               end
            endcase
         end
         StExec: begin
            alu_src_imm = (cls_q == ClsIalu) || (cls_q == ClsLoad) ||
                          (cls_q == ClsStore) || (cls_q == ClsLui);
            if (cls_q == ClsBranch) taken_d = branch_taken;
            state_d = ((cls_q == ClsLoad) || (cls_q == ClsStore)) ? StMem : StWb;
         end
         StMem: begin
            mem.dmem_req = 1'b1;
            mem.dmem_we  = (cls_q == ClsStore);
            alu_src_imm  = 1'b1;
            if (mem.dmem_ack) begin
               state_d = StWb;
            end else if (wait_q == LastWait) begin
               state_d = StTrap;
               cause_d = CauseDmem;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         StWb: begin
            pc_we     = 1'b1;
            reg_write = (cls_q != ClsStore) && (cls_q != ClsBranch);
            if (cls_q == ClsLoad)     wb_sel = 2'd1;
            else if (cls_q == ClsJal) wb_sel = 2'd2;
            if (cls_q == ClsJal)                   pc_sel = 2'd2;
            else if (cls_q == ClsBranch && taken_q) pc_sel = 2'd1;
            instret_d = instret_q + CNT_W'(1);
            state_d   = run ? StFetch : StIdle;
         end
         StTrap: begin
            trap = 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Every state entry starts a fresh timeout window.
      if (state_d != state_q) wait_d = '0;
   end

   assign trap_cause = cause_q;
   assign state_o    = state_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_cayde_ctrl_fsm.sv
// Self-checking bench for cayde_ctrl_fsm: directed vector table, randomized instruction stream
// against an instruction-level latency model, plus reset, trap and timeout sequences.
module tb_cayde_ctrl_fsm;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 32;

   typedef struct packed {
      logic [2:0]  st;
      logic        imem_req;
      logic        ir_we;
      logic        dmem_req;
      logic        dmem_we;
      logic        alu_imm;
      logic [1:0]  wb;
      logic [1:0]  pc;
      logic        pc_we;
      logic        rw;
      logic        trap;
      logic [1:0]  cause;
      logic [31:0] instret;
   } outs_t;

   typedef struct {
      logic [6:0] op;
      logic       taken;
      int         iw;
      int         dw;
      bit         illegal;
      bit         imm;
      bit         mem;
      bit         st;
      logic [1:0] wb;
      logic [1:0] pc;
      bit         rw;
   } vec_t;

   logic             clk;
   logic             rst;
   logic             run;
   logic [6:0]       opcode;
   logic             branch_taken;
   logic             ir_we;
   logic             alu_src_imm;
   logic [1:0]       wb_sel;
   logic [1:0]       pc_sel;
   logic             pc_we;
   logic             reg_write;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [2:0]       state_o;
   logic [CNT_W-1:0] instret;

   int vectors  = 0;
   int failures = 0;
   int exp_instret = 0;

   cayde_ctrl_fsm_if mem_if ();

   cayde_ctrl_fsm #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem          (mem_if),
      .run          (run),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .ir_we        (ir_we),
      .alu_src_imm  (alu_src_imm),
      .wb_sel       (wb_sel),
      .pc_sel       (pc_sel),
      .pc_we        (pc_we),
      .reg_write    (reg_write),
      .trap         (trap),
      .trap_cause   (trap_cause),
      .state_o      (state_o),
      .instret      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic outs_t mk_out(input logic [2:0] st);
      outs_t e;
      e = '0;
      e.st = st;
      e.instret = 32'(exp_instret);
      return e;
   endfunction

   // Instruction attributes derived directly from the opcode table.
   function automatic vec_t attrs(input logic [6:0] op, input logic t, input int iw, input int dw);
      vec_t v;
      v = '{default: '0};
      v.op = op; v.taken = t; v.iw = iw; v.dw = dw;
      case (op)
         7'b0110011: v.rw = 1;
         7'b0010011: begin v.imm = 1; v.rw = 1; end
         7'b0000011: begin v.imm = 1; v.mem = 1; v.rw = 1; v.wb = 2'd1; end
         7'b0100011: begin v.imm = 1; v.mem = 1; v.st = 1; end
         7'b1100011: v.pc = t ? 2'd1 : 2'd0;
         7'b1101111: begin v.rw = 1; v.wb = 2'd2; v.pc = 2'd2; end
         7'b0110111: begin v.imm = 1; v.rw = 1; end
         default:    v.illegal = 1;
      endcase
      return v;
   endfunction

   function automatic vec_t mk_vec(input logic [6:0] op, input logic t, input int iw, input int dw,
                                   input bit imm, input bit m, input bit st, input logic [1:0] wb,
                                   input logic [1:0] pc, input bit rw);
      vec_t v;
      v = '{default: '0};
      v.op = op; v.taken = t; v.iw = iw; v.dw = dw;
      v.imm = imm; v.mem = m; v.st = st; v.wb = wb; v.pc = pc; v.rw = rw;
      return v;
   endfunction

   task automatic check_now(input string tag, input outs_t e);
      outs_t a;
      a = '{st: state_o, imem_req: mem_if.imem_req, ir_we: ir_we, dmem_req: mem_if.dmem_req,
            dmem_we: mem_if.dmem_we, alu_imm: alu_src_imm, wb: wb_sel, pc: pc_sel, pc_we: pc_we,
            rw: reg_write, trap: trap, cause: trap_cause, instret: instret};
      vectors++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %h want %h (st %0d/%0d instret %0d/%0d)", tag, a, e,
                  a.st, e.st, a.instret, e.instret);
      end
   endtask

   task automatic cyc(input string tag, input logic r, input logic ia, input logic da,
                      input logic bt, input outs_t e);
      @(negedge clk);
      run = r;
      mem_if.imem_ack = ia;
      mem_if.dmem_ack = da;
      branch_taken = bt;
      #1;
      check_now(tag, e);
   endtask

   task automatic trap_seq(input logic [1:0] cause);
      outs_t e;
      for (int k = 0; k < 3; k++) begin
         e = mk_out(3'd6);
         e.trap = 1'b1;
         e.cause = cause;
         cyc("trap_hold", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), e);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      run = 1'b0;
      mem_if.imem_ack = 1'b0;
      mem_if.dmem_ack = 1'b0;
      exp_instret = 0;
      #1;
      check_now("reset", mk_out(3'd0));
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Drives one instruction starting in FETCH; checks every cycle against the latency model.
   task automatic exec_instr(input vec_t v, input logic run_after, output bit trapped);
      outs_t e;
      trapped = 1'b0;
      opcode = v.op;
      for (int k = 0; k <= v.iw; k++) begin
         if (k == TIMEOUT) begin
            trap_seq(2'd2);
            trapped = 1'b1;
            return;
         end
         e = mk_out(3'd1);
         e.imem_req = 1'b1;
         e.ir_we = (k == v.iw);
         cyc("fetch", 1'b1, k == v.iw, 1'($urandom), 1'($urandom), e);
      end
      cyc("decode", 1'b1, 1'b0, 1'b0, 1'($urandom), mk_out(3'd2));
      if (v.illegal) begin
         trap_seq(2'd1);
         trapped = 1'b1;
         return;
      end
      e = mk_out(3'd3);
      e.alu_imm = v.imm;
      cyc("exec", run_after, 1'b0, 1'b0, v.taken, e);
      if (v.mem) begin
         for (int k = 0; k <= v.dw; k++) begin
            if (k == TIMEOUT) begin
               trap_seq(2'd3);
               trapped = 1'b1;
               return;
            end
            e = mk_out(3'd4);
            e.dmem_req = 1'b1;
            e.dmem_we = v.st;
            e.alu_imm = 1'b1;
            cyc("mem", run_after, 1'($urandom), k == v.dw, ~v.taken, e);
         end
      end
      e = mk_out(3'd5);
      e.pc_we = 1'b1;
      e.rw = v.rw;
      e.wb = v.wb;
      e.pc = v.pc;
      cyc("wb", run_after, 1'b0, 1'b0, ~v.taken, e);
      exp_instret++;
   endtask

   vec_t       tbl [10];
   logic [6:0] legal_ops [7];
   bit         trapped;
   outs_t      e;

   initial begin
      tbl[0] = mk_vec(7'b0110011, 1'b0, 0,  0, 0, 0, 0, 2'd0, 2'd0, 1);
      tbl[1] = mk_vec(7'b0010011, 1'b0, 1,  0, 1, 0, 0, 2'd0, 2'd0, 1);
      tbl[2] = mk_vec(7'b0000011, 1'b0, 0,  3, 1, 1, 0, 2'd1, 2'd0, 1);
      tbl[3] = mk_vec(7'b0100011, 1'b0, 0,  2, 1, 1, 1, 2'd0, 2'd0, 0);
      tbl[4] = mk_vec(7'b1100011, 1'b1, 0,  0, 0, 0, 0, 2'd0, 2'd1, 0);
      tbl[5] = mk_vec(7'b1100011, 1'b0, 0,  0, 0, 0, 0, 2'd0, 2'd0, 0);
      tbl[6] = mk_vec(7'b1101111, 1'b0, 2,  0, 0, 0, 0, 2'd2, 2'd2, 1);
      tbl[7] = mk_vec(7'b0110111, 1'b0, 0,  0, 1, 0, 0, 2'd0, 2'd0, 1);
      tbl[8] = mk_vec(7'b0110011, 1'b0, 15, 0, 0, 0, 0, 2'd0, 2'd0, 1);
      tbl[9] = mk_vec(7'b0000011, 1'b0, 0, 15, 1, 1, 0, 2'd1, 2'd0, 1);
      legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                    7'b1100011, 7'b1101111, 7'b0110111};

      opcode = 7'b0110011;
      branch_taken = 1'b0;
      do_reset();

      cyc("idle_hold", 1'b0, 1'b1, 1'b1, 1'b0, mk_out(3'd0));
      cyc("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0, mk_out(3'd0));
      cyc("idle_go", 1'b1, 1'b0, 1'b0, 1'b0, mk_out(3'd0));

      // Back-to-back zero-wait R-type stream.
      for (int i = 0; i < 3; i++) exec_instr(tbl[0], 1'b1, trapped);

      for (int i = 0; i < 10; i++) exec_instr(tbl[i], 1'b1, trapped);

      // run dropped during EXEC: the instruction still retires, then the core idles.
      exec_instr(tbl[2], 1'b0, trapped);
      cyc("idle_after_halt", 1'b0, 1'b1, 1'b0, 1'b0, mk_out(3'd0));
      cyc("idle_after_halt", 1'b0, 1'b0, 1'b0, 1'b0, mk_out(3'd0));
      cyc("idle_go", 1'b1, 1'b0, 1'b0, 1'b0, mk_out(3'd0));

      for (int i = 0; i < 40; i++) begin
         exec_instr(attrs(legal_ops[$urandom_range(6)], 1'($urandom),
                          int'($urandom_range(4)), int'($urandom_range(4))), 1'b1, trapped);
      end

      // Reset asserted in the middle of a MEM wait drops dmem_req at once.
      opcode = 7'b0000011;
      e = mk_out(3'd1); e.imem_req = 1'b1; e.ir_we = 1'b1;
      cyc("fetch", 1'b1, 1'b1, 1'b0, 1'b0, e);
      cyc("decode", 1'b1, 1'b0, 1'b0, 1'b0, mk_out(3'd2));
      e = mk_out(3'd3); e.alu_imm = 1'b1;
      cyc("exec", 1'b1, 1'b0, 1'b0, 1'b0, e);
      e = mk_out(3'd4); e.dmem_req = 1'b1; e.alu_imm = 1'b1;
      cyc("mem_pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, e);
      #2;
      rst = 1'b0;
      run = 1'b0;
      exp_instret = 0;
      #1;
      check_now("rst_mid_mem", mk_out(3'd0));
      @(negedge clk);
      rst = 1'b1;
      cyc("idle_go", 1'b1, 1'b0, 1'b0, 1'b0, mk_out(3'd0));

      exec_instr(attrs(7'b1111111, 1'b0, 0, 0), 1'b1, trapped);
      do_reset();
      cyc("idle_go", 1'b1, 1'b0, 1'b0, 1'b0, mk_out(3'd0));

      exec_instr(attrs(7'b0110011, 1'b0, 20, 0), 1'b1, trapped);
      do_reset();
      cyc("idle_go", 1'b1, 1'b0, 1'b0, 1'b0, mk_out(3'd0));

      exec_instr(attrs(7'b0000011, 1'b0, 1, 20), 1'b1, trapped);
      do_reset();
      cyc("idle_final", 1'b0, 1'b0, 1'b0, 1'b0, mk_out(3'd0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
      $finish;
   end

endmodule
